// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit with stall handshake, variable-latency memory port and response timeout.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned accesses (beat-crossing ones split in two); otherwise they are rejected.
module lsu_mem_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            busy,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            misalign_err,
    output logic            bus_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [31:0]     mem_address,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_byte_enable,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_resp
);
    localparam int BYTES = DW / 8;
    localparam int LB    = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ACC1,
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC2,
`endif
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic             r_store;
    logic [2:0]       r_f3;
    logic [31:0]      r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    lo;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [DW-1:0]    hi;
    logic [BYTES-1:0] be2;
    logic [DW-1:0]    wd2;
    logic             cross;
`endif
    logic [31:0]      cnt;
    logic             berr;

    logic [1:0]       code;
    int               nb;
    logic [LB-1:0]    ofs;
    logic [31:0]      base;
    logic [BYTES-1:0] be1;
    logic [DW-1:0]    wd1;
    logic [DW-1:0]    word;
    logic [DW-1:0]    mask;
    logic [DW-1:0]    ext;
    logic             sgn;
    logic             tmo;
    logic             acc;

    // doubleword encoding on a 32-bit bus degrades to a word access
    function automatic logic [1:0] size_code(input logic [2:0] f3);
        return (DW == 32 && f3[1:0] == 2'd3) ? 2'd2 : f3[1:0];
    endfunction

    // lane placement, load extraction/extension and output decode from the registered request
    always_comb begin
        code = size_code(r_f3);
        nb = 1 << code;
        ofs = r_addr[LB-1:0];
        base = {r_addr[31:LB], {LB{1'b0}}};
        be1 = BYTES'(((1 << nb) - 1) << ofs);
        wd1 = r_wdata << {ofs, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
        be2 = BYTES'((((1 << nb) - 1) << ofs) >> BYTES);
        wd2 = r_wdata >> (DW - 8 * int'(ofs));
        cross = int'(ofs) + nb > BYTES;
        word = DW'({hi, lo} >> {ofs, 3'b000});
        acc = state == ACC1 || state == ACC2;
        mem_address = acc ? base + (state == ACC2 ? 32'(BYTES) : 32'd0) : '0;
        mem_byte_enable = (acc && r_store) ? (state == ACC2 ? be2 : be1) : '0;
        mem_wdata = (acc && r_store) ? (state == ACC2 ? wd2 : wd1) : '0;
`else
        word = lo >> {ofs, 3'b000};
        acc = state == ACC1;
        mem_address = acc ? base : '0;
        mem_byte_enable = (acc && r_store) ? be1 : '0;
        mem_wdata = (acc && r_store) ? wd1 : '0;
`endif
        mask = (DW'(1) << (8 << code)) - DW'(1);
        sgn = ~r_f3[2] & |(word & mask & ~(mask >> 1));
        ext = (word & mask) | (sgn ? ~mask : '0);
        tmo = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
        mem_read = acc & ~r_store;
        mem_write = acc & r_store;
        rsp_valid = state == DONE || state == ERR;
        misalign_err = state == ERR;
        bus_err = state == DONE && berr;
        rsp_rdata = (state == DONE && !berr && !r_store) ? ext : '0;
        busy = req_valid & ~rsp_valid;
    end

    // access sequencer: capture request, run one or two beats, time out, then report
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r_store <= 1'b0;
            r_f3 <= '0;
            r_addr <= '0;
            r_wdata <= '0;
            lo <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi <= '0;
`endif
            cnt <= '0;
            berr <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_store <= req_store;
                    r_f3 <= req_funct3;
                    r_addr <= req_addr;
                    r_wdata <= req_wdata;
                    cnt <= '0;
                    berr <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    state <= ACC1;
`else
                    state <= |(req_addr[2:0] & 3'((4'd1 << size_code(req_funct3)) - 4'd1)) ? ERR : ACC1;
`endif
                end
                ACC1: if (mem_resp) begin
                    lo <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                    state <= cross ? ACC2 : DONE;
`else
                    state <= DONE;
`endif
                end else if (tmo) begin
                    berr <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 32'd1;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC2: if (mem_resp) begin
                    hi <= mem_rdata;
                    state <= DONE;
                end else if (tmo) begin
                    berr <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 32'd1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
